// File: rtl/debounce_pkg.sv
// Shared constants and width helper for the multi-channel button debouncer.
package debounce_pkg;

  localparam int unsigned DEB_TICK_DIV_DEFAULT     = 500000;
  localparam int unsigned DEB_STABLE_TICKS_DEFAULT = 3;

  // Counter width for a range of x states; never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned x);
    return (x <= 32'd1) ? 32'd1 : 32'($clog2(x));
  endfunction

endpackage

// File: rtl/debounce_multi_if.sv
// Button-side and peripheral-side signals of the multi-channel debouncer.
interface debounce_multi_if #(
  parameter int unsigned CHANNELS = 4
);

  logic [CHANNELS-1:0] buttons_i;
  logic [CHANNELS-1:0] level_o;
  logic [CHANNELS-1:0] rise_o;
  logic [CHANNELS-1:0] fall_o;
  logic                tick_o;

  modport master (output buttons_i, input level_o, rise_o, fall_o, tick_o);
  modport slave  (input buttons_i, output level_o, rise_o, fall_o, tick_o);

endinterface

// File: rtl/debounce_channel.sv
// One debounce channel: 2-flop synchroniser, tick-driven stability counter,
// registered level and single-cycle rise/fall pulses.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int unsigned STABLE_TICKS = DEB_STABLE_TICKS_DEFAULT,
  parameter logic        RESET_LEVEL  = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic button,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int unsigned SW = cnt_w(STABLE_TICKS + 1);

  logic [1:0]    sync_q;
  logic          sync;
  logic [SW-1:0] cnt_q;
  logic [SW-1:0] cnt_d;
  logic          level_d;
  logic          rise_d;
  logic          fall_d;

  assign sync = sync_q[1];

  // Any reversion to the accepted level restarts the window from zero.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (sync == level) begin
      cnt_d = '0;
    end else if (tick) begin
      if (cnt_q == SW'(STABLE_TICKS - 1)) begin
        cnt_d   = '0;
        level_d = sync;
        rise_d  = sync;
        fall_d  = ~sync;
      end else begin
        cnt_d = cnt_q + SW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {2{RESET_LEVEL}};
      cnt_q  <= '0;
      level  <= RESET_LEVEL;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], button};
      cnt_q  <= cnt_d;
      level  <= level_d;
      rise   <= rise_d;
      fall   <= fall_d;
    end
  end

endmodule

// File: rtl/debounce_multi.sv
// Multi-channel push-button debouncer: one free-running tick prescaler shared
// by CHANNELS independent debounce_channel filters.
module debounce_multi
  import debounce_pkg::*;
#(
  parameter int unsigned CHANNELS     = 4,
  parameter int unsigned TICK_DIV     = DEB_TICK_DIV_DEFAULT,
  parameter int unsigned STABLE_TICKS = DEB_STABLE_TICKS_DEFAULT,
  parameter logic        RESET_LEVEL  = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  debounce_multi_if.slave  bus
);

  localparam int unsigned PW = cnt_w(TICK_DIV);

  logic [PW-1:0]       div_q;
  logic [PW-1:0]       div_d;
  logic                tick_q;
  logic                tick_d;
  logic [CHANNELS-1:0] level;
  logic [CHANNELS-1:0] rise;
  logic [CHANNELS-1:0] fall;

  // tick_q is registered from the next count so it is high while div_q == TICK_DIV-1.
  always_comb begin
    div_d  = (div_q == PW'(TICK_DIV - 1)) ? '0 : div_q + PW'(1);
    tick_d = (div_d == PW'(TICK_DIV - 1));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      div_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      tick_q <= tick_d;
    end
  end

  for (genvar i = 0; i < int'(CHANNELS); i++) begin : g_ch
    debounce_channel #(
      .STABLE_TICKS (STABLE_TICKS),
      .RESET_LEVEL  (RESET_LEVEL)
    ) u_ch (
      .clk    (clk_i),
      .rst    (rst_i),
      .tick   (tick_q),
      .button (bus.buttons_i[i]),
      .level  (level[i]),
      .rise   (rise[i]),
      .fall   (fall[i])
    );
  end

  assign bus.level_o = level;
  assign bus.rise_o  = rise;
  assign bus.fall_o  = fall;
  assign bus.tick_o  = tick_q;

endmodule

// File: tb/tb_debounce_multi.sv
// Directed self-checking bench for debounce_multi: main 4-channel instance
// plus a fast 1-channel corner instance and a RESET_LEVEL=1 instance.
module tb_debounce_multi;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  debounce_multi_if #(.CHANNELS(4)) bus_main ();
  debounce_multi_if #(.CHANNELS(1)) bus_fast ();
  debounce_multi_if #(.CHANNELS(4)) bus_rl1 ();

  debounce_multi #(.CHANNELS(4), .TICK_DIV(8), .STABLE_TICKS(3), .RESET_LEVEL(1'b0))
    u_dut (.clk_i(clk), .rst_i(rst), .bus(bus_main));
  debounce_multi #(.CHANNELS(1), .TICK_DIV(1), .STABLE_TICKS(1), .RESET_LEVEL(1'b0))
    u_fast (.clk_i(clk), .rst_i(rst), .bus(bus_fast));
  debounce_multi #(.CHANNELS(4), .TICK_DIV(8), .STABLE_TICKS(3), .RESET_LEVEL(1'b1))
    u_rl1 (.clk_i(clk), .rst_i(rst), .bus(bus_rl1));

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int rise_cnt [4];
  int fall_cnt [4];
  int overlap = 0;
  int rl1_pulses = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s got=%0h want=%0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  task automatic clear_cnt();
    for (int i = 0; i < 4; i++) begin
      rise_cnt[i] = 0;
      fall_cnt[i] = 0;
    end
  endtask

  // Advance one clock and sample 1 ns after the edge; cyc counts edges since reset release.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < 4; i++) begin
      rise_cnt[i] += int'(bus_main.rise_o[i]);
      fall_cnt[i] += int'(bus_main.fall_o[i]);
    end
    if ((bus_main.rise_o & bus_main.fall_o) != 4'h0) overlap++;
    if ((bus_rl1.rise_o | bus_rl1.fall_o) != 4'h0) rl1_pulses++;
  endtask

  // Cycle index at which the level flips for an input changed right after edge c:
  // sync sees it from cycle c+2, ticks are the cycles with index mod div == div-1.
  function automatic int accept_cycle(input int c, input int div, input int st);
    int n = 0;
    for (int t = c + 2; t < c + 2 + div * (st + 1); t++) begin
      if (t % div == div - 1) begin
        n++;
        if (n == st) return t + 1;
      end
    end
    return -1;
  endfunction

  task automatic wait_level0(input logic want, input int budget, output int at, output bit seen);
    seen = 1'b0;
    at = -1;
    for (int i = 0; i < budget && !seen; i++) begin
      step();
      if (bus_main.level_o[0] == want) begin
        seen = 1'b1;
        at = cyc;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int want_at;
    int at;
    bit seen;
    logic [3:0] fall_mask;

    bus_main.buttons_i = 4'hF;
    bus_fast.buttons_i = 1'b0;
    bus_rl1.buttons_i  = 4'hF;
    clear_cnt();

    // Reset held 3 cycles with all buttons high
    #2 rst = 1'b1;
    #1;
    check_eq("rst_level", 32'(bus_main.level_o), 32'h0);
    check_eq("rst_pulses", 32'(bus_main.rise_o | bus_main.fall_o), 32'h0);
    check_eq("rst_tick", 32'(bus_main.tick_o), 32'h0);
    check_eq("rst_rl1_level", 32'(bus_rl1.level_o), 32'hF);
    repeat (3) step();
    check_eq("rst_hold_level", 32'(bus_main.level_o), 32'h0);
    check_eq("rst_hold_tick", 32'(bus_main.tick_o), 32'h0);
    rst = 1'b0;
    bus_main.buttons_i = 4'h0;
    cyc = 0;
    check_eq("rel_tick", 32'(bus_main.tick_o), 32'h0);
    for (int k = 1; k <= 8; k++) begin
      step();
      check_eq($sformatf("tick_phase_%0d", k), 32'(bus_main.tick_o), 32'(k == 7));
    end
    check_eq("rel_level", 32'(bus_main.level_o), 32'h0);

    // Clean press on channel 0
    clear_cnt();
    c = cyc;
    want_at = accept_cycle(c, 8, 3);
    bus_main.buttons_i = 4'b0001;
    wait_level0(1'b1, 40, at, seen);
    check_eq("press_seen", 32'(seen), 32'h1);
    check_eq("press_latency", 32'(at), 32'(want_at));
    check_eq("press_window", 32'((at - c) >= 19 && (at - c) <= 26), 32'h1);
    check_eq("press_rise", 32'(bus_main.rise_o), 32'b0001);
    check_eq("press_level", 32'(bus_main.level_o), 32'b0001);
    step();
    check_eq("press_rise_drop", 32'(bus_main.rise_o), 32'h0);
    check_eq("press_rise_cnt", 32'(rise_cnt[0]), 32'd1);

    // Bounce on channel 1: 5-cycle segments never accumulate three ticks
    clear_cnt();
    for (int s = 0; s < 8; s++) begin
      bus_main.buttons_i[1] = (s % 2 == 0);
      repeat (5) step();
    end
    check_eq("bounce_press_quiet", 32'(rise_cnt[1] + fall_cnt[1]), 32'h0);
    bus_main.buttons_i[1] = 1'b1;
    repeat (40) step();
    check_eq("bounce_rise_cnt", 32'(rise_cnt[1]), 32'd1);
    check_eq("bounce_level", 32'(bus_main.level_o[1]), 32'h1);
    for (int s = 0; s < 8; s++) begin
      bus_main.buttons_i[1] = (s % 2 == 1);
      repeat (5) step();
    end
    check_eq("bounce_release_quiet", 32'(fall_cnt[1]), 32'h0);
    bus_main.buttons_i[1] = 1'b0;
    repeat (40) step();
    check_eq("bounce_fall_cnt", 32'(fall_cnt[1]), 32'd1);
    check_eq("bounce_rise_total", 32'(rise_cnt[1]), 32'd1);
    check_eq("bounce_other_chan", 32'(rise_cnt[2] + rise_cnt[3] + fall_cnt[0]), 32'h0);

    // Simultaneous press of all channels, then release of channels 2 and 3
    bus_main.buttons_i = 4'h0;
    repeat (40) step();
    check_eq("simul_idle", 32'(bus_main.level_o), 32'h0);
    clear_cnt();
    bus_main.buttons_i = 4'hF;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step();
      seen = (bus_main.level_o != 4'h0);
    end
    check_eq("simul_seen", 32'(seen), 32'h1);
    check_eq("simul_level", 32'(bus_main.level_o), 32'hF);
    check_eq("simul_rise", 32'(bus_main.rise_o), 32'hF);
    step();
    bus_main.buttons_i = 4'b0011;
    repeat (40) step();
    fall_mask = '0;
    for (int i = 0; i < 4; i++) fall_mask[i] = (fall_cnt[i] == 1);
    check_eq("simul_fall_mask", 32'(fall_mask), 32'b1100);
    check_eq("simul_fall_ch01", 32'(fall_cnt[0] + fall_cnt[1]), 32'h0);
    check_eq("simul_level_after", 32'(bus_main.level_o), 32'b0011);

    // Reset in the middle of a pending press
    bus_main.buttons_i = 4'h0;
    repeat (40) step();
    check_eq("midrst_idle", 32'(bus_main.level_o), 32'h0);
    bus_main.buttons_i = 4'b0001;
    repeat (15) step();
    rst = 1'b1;
    #1;
    check_eq("midrst_level", 32'(bus_main.level_o), 32'h0);
    check_eq("midrst_rise", 32'(bus_main.rise_o), 32'h0);
    step();
    step();
    rst = 1'b0;
    cyc = 0;
    clear_cnt();
    want_at = accept_cycle(0, 8, 3);
    wait_level0(1'b1, 40, at, seen);
    check_eq("midrst_seen", 32'(seen), 32'h1);
    check_eq("midrst_latency", 32'(at), 32'(want_at));
    check_eq("midrst_latency_abs", 32'(at), 32'd24);
    check_eq("midrst_rise_cnt", 32'(rise_cnt[0]), 32'd1);

    // TICK_DIV=1, STABLE_TICKS=1: level follows three cycles after a change
    bus_fast.buttons_i = 1'b1;
    step();
    step();
    check_eq("fast_level_c2", 32'(bus_fast.level_o), 32'h0);
    step();
    check_eq("fast_level_c3", 32'(bus_fast.level_o), 32'h1);
    check_eq("fast_rise_c3", 32'(bus_fast.rise_o), 32'h1);
    bus_fast.buttons_i = 1'b0;
    step();
    check_eq("fast_rise_drop", 32'(bus_fast.rise_o), 32'h0);
    step();
    step();
    check_eq("fast_fall_c3", 32'(bus_fast.fall_o), 32'h1);
    check_eq("fast_level_low", 32'(bus_fast.level_o), 32'h0);

    // Whole-run invariants
    check_eq("pulse_exclusive", 32'(overlap), 32'h0);
    check_eq("rl1_no_pulse", 32'(rl1_pulses), 32'h0);
    check_eq("rl1_level", 32'(bus_rl1.level_o), 32'hF);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
